// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way bus arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4.sv
// Parameterised 4:1 mux used on the shared bus data path.
module mux4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic [WIDTH-1:0] in3_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        unique case (sel_i)
            2'd0:    out_o = in0_i;
            2'd1:    out_o = in1_i;
            2'd2:    out_o = in2_i;
            default: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set candidate searching upward from last+1, wrapping.
module rr_pick4 (
    input  logic [3:0] cand,
    input  logic [1:0] last,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        win = 2'd0;
        any = 1'b0;
        idx = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!any && cand[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter sharing one bus slave port among 4 requesters, with a
// watchdog that aborts transfers the slave never completes.
module bus_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [1:0]               sel,
    output logic                     bus_valid,
    output logic [WIDTH-1:0]         bus_data,
    input  logic                     bus_ready,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       err
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic [NUM_REQ-1:0] cand;
    logic [1:0]         win;
    logic               any;

    // While busy the current owner is masked so a completion hands over fairly.
    assign cand = (state_q == BUSY) ? (req & ~grant_q) : req;

    rr_pick4 u_pick (
        .cand (cand),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (sel_q),
        .in0_i (req_data[0*WIDTH +: WIDTH]),
        .in1_i (req_data[1*WIDTH +: WIDTH]),
        .in2_i (req_data[2*WIDTH +: WIDTH]),
        .in3_i (req_data[3*WIDTH +: WIDTH]),
        .out_o (bus_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BUSY;
                    grant_d = onehot4(win);
                    sel_d   = win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // A ready on the timeout cycle still counts as a normal completion.
                if (bus_ready) begin
                    cnt_d = '0;
                    if (any) begin
                        grant_d = onehot4(win);
                        sel_d   = win;
                        last_d  = win;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    err_d   = grant_q;
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant     = grant_q;
        sel       = sel_q;
        bus_valid = (state_q == BUSY);
        ack       = (state_q == BUSY && bus_ready) ? grant_q : '0;
        err       = err_q;
    end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Self-checking bench for bus_arbiter_4: directed vector table, hand-written
// watchdog/collision/reset sequences, and random traffic against a reference model.
module tb_bus_arbiter_4;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         req = '0;
    logic [4*WIDTH-1:0] req_data = '0;
    logic [3:0]         grant;
    logic [1:0]         sel;
    logic               bus_valid;
    logic [WIDTH-1:0]   bus_data;
    logic               bus_ready = 1'b0;
    logic [3:0]         ack;
    logic [3:0]         err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_arbiter_4 #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_ready (bus_ready),
        .ack       (ack),
        .err       (err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic rdy,
                                input logic [3:0] g, input logic [1:0] s, input logic v,
                                input logic [3:0] a);
        vec_t x;
        x.rst = rst; x.req = r; x.rdy = rdy; x.grant = g; x.sel = s; x.valid = v; x.ack = a;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_waited;
    logic [3:0] m_err;

    function automatic int rr_pick(input logic [3:0] c, input int last);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (last + k) % 4;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 3; m_waited = 0; m_err = '0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic rdy);
        logic [3:0] nerr;
        int w;
        nerr = '0;
        if (!m_busy) begin
            w = rr_pick(r, m_last);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_last = w; m_waited = 0;
            end
        end else if (rdy) begin
            w = rr_pick(r & ~(4'b0001 << m_owner), m_last);
            m_waited = 0;
            if (w >= 0) begin
                m_owner = w; m_last = w;
            end else begin
                m_busy = 0;
            end
        end else if (m_waited + 1 == int'(MAX_WAIT)) begin
            nerr = 4'b0001 << m_owner;
            m_busy = 0;
            m_waited = 0;
        end else begin
            m_waited++;
        end
        m_err = nerr;
    endtask

    initial begin
        req_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

        // single request, ready on the 2nd busy cycle, then ready while idle
        tbl.push_back(mk(1, 4'b0001, 0, 4'b0000, 2'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 4'b0000));
        tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 2'd0, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 4'b0000));
        // round-robin fairness, no bubbles
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 4'b0001));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 4'b0010));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 4'b0100));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 4'b1000));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 4'b0000));
        // lone requester re-asserting: one idle cycle between grants
        tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 2'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 2'd2, 1, 4'b0100));
        tbl.push_back(mk(0, 4'b0100, 0, 4'b0000, 2'd0, 0, 4'b0000));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 2'd2, 1, 4'b0100));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 4'b0000));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req;
            bus_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d.valid", i), 32'(bus_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d.ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d.err", i), 32'(err), 32'h0);
            if (tbl[i].valid || tbl[i].rst)
                chk($sformatf("tbl%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
            if (tbl[i].valid)
                chk($sformatf("tbl%0d.data", i), bus_data,
                    req_data[32'(tbl[i].sel)*WIDTH +: WIDTH]);
            tick();
        end

        // watchdog: grant at cycle 1, err on cycle 5, then rotation starts at 2
        do_reset();
        req = 4'b0010;
        #1;
        chk("wd.idle", 32'(grant), 32'h0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wd.grant%0d", c), 32'(grant), 32'h2);
            chk($sformatf("wd.noerr%0d", c), 32'(err), 32'h0);
            tick();
        end
        req = 4'b0000;
        #1;
        chk("wd.err", 32'(err), 32'h2);
        chk("wd.grant_drop", 32'(grant), 32'h0);
        chk("wd.valid_drop", 32'(bus_valid), 32'h0);
        chk("wd.ack_none", 32'(ack), 32'h0);
        tick();
        req = 4'b1111;
        #1;
        chk("wd.err_1cyc", 32'(err), 32'h0);
        tick();
        chk("wd.next_grant", 32'(grant), 32'h4);
        chk("wd.next_sel", 32'(sel), 32'h2);

        // ready arriving on the timeout cycle wins
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 1; c <= 3; c++) tick();
        bus_ready = 1'b1;
        #1;
        chk("col.ack", 32'(ack), 32'h1);
        chk("col.err", 32'(err), 32'h0);
        tick();
        req = 4'b0000;
        bus_ready = 1'b0;
        #1;
        chk("col.err_after", 32'(err), 32'h0);
        chk("col.idle", 32'(grant), 32'h0);
        tick();

        // asynchronous reset in the middle of a transfer
        do_reset();
        req = 4'b0100;
        tick();
        chk("ar.busy", 32'(grant), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.grant", 32'(grant), 32'h0);
        chk("ar.valid", 32'(bus_valid), 32'h0);
        chk("ar.sel", 32'(sel), 32'h0);
        chk("ar.ack", 32'(ack), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;
        #1;
        chk("ar.err", 32'(err), 32'h0);
        tick();
        chk("ar.first", 32'(grant), 32'h1);

        // random traffic against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] eg;
            req = 4'($urandom_range(0, 15));
            bus_ready = ($urandom_range(0, 9) < 3);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            #1;
            chk("rnd.grant", 32'(grant), 32'(eg));
            chk("rnd.valid", 32'(bus_valid), 32'(m_busy));
            chk("rnd.ack", 32'(ack), (m_busy && bus_ready) ? 32'(eg) : 32'h0);
            chk("rnd.err", 32'(err), 32'(m_err));
            if (m_busy) begin
                chk("rnd.sel", 32'(sel), 32'(m_owner));
                chk("rnd.data", bus_data, req_data[m_owner*WIDTH +: WIDTH]);
            end
            @(posedge clk);
            model_step(req, bus_ready);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
